// File: rtl/mod_74x161_pkg.sv
// rtl/mod_74x161_pkg.sv - shared constants for the 74x161 counter model and its bench
package mod_74x161_pkg;

    localparam int WIDTH_DEF   = 4;
    localparam int HALF_PERIOD = 5;

endpackage

// File: rtl/mod_74x161_if.sv
// rtl/mod_74x161_if.sv - load/enable/data/count bundle of the 74x161 counter
interface mod_74x161_if #(
    parameter int WIDTH = mod_74x161_pkg::WIDTH_DEF
);

    logic             load_n;
    logic             enp;
    logic             ent;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             rco;

    modport master (
        output load_n, enp, ent, d,
        input  q, rco
    );

    modport slave (
        input  load_n, enp, ent, d,
        output q, rco
    );

endinterface

// File: rtl/mod_74x161.sv
// rtl/mod_74x161.sv - presettable binary counter with async clear, modelled on the 74x161
module mod_74x161
    import mod_74x161_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic          clk,
    input  logic          clr_n,
    mod_74x161_if.slave   bus
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count;

    // Load outranks counting; clear outranks everything and needs no edge.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count <= '0;
        end else if (!bus.load_n) begin
            count <= bus.d;
        end else if (bus.enp && bus.ent) begin
            count <= count + ONE;
        end
    end

    assign bus.q   = count;
    // Carry is combinational so a cascaded stage sees it before the wrapping edge.
    assign bus.rco = bus.ent & (&count);

endmodule

// File: tb/tb_mod_74x161.sv
// tb/tb_mod_74x161.sv - scoreboard bench for a single counter and a two-stage cascade
module tb_mod_74x161;
    import mod_74x161_pkg::*;

    typedef struct {
        logic       clr_n;
        logic       load_n;
        logic       enp;
        logic       ent;
        logic [3:0] d;
        logic       c_load_n;
        logic       c_enp;
        logic       c_ent;
        logic [7:0] c_d;
    } stim_t;

    typedef struct {
        logic [14:0] v;
        string       tag;
    } exp_t;

    logic  clk;
    stim_t cur;
    exp_t  sb[$];
    int    vectors;
    int    miscompares;
    int    mq;
    int    mc;
    bit    stim_done;

    mod_74x161_if #(.WIDTH(4)) m_if ();
    mod_74x161_if #(.WIDTH(4)) lo_if ();
    mod_74x161_if #(.WIDTH(4)) hi_if ();

    assign m_if.load_n  = cur.load_n;
    assign m_if.enp     = cur.enp;
    assign m_if.ent     = cur.ent;
    assign m_if.d       = cur.d;
    assign lo_if.load_n = cur.c_load_n;
    assign lo_if.enp    = cur.c_enp;
    assign lo_if.ent    = cur.c_ent;
    assign lo_if.d      = cur.c_d[3:0];
    assign hi_if.load_n = cur.c_load_n;
    assign hi_if.enp    = cur.c_enp;
    assign hi_if.ent    = lo_if.rco;
    assign hi_if.d      = cur.c_d[7:4];

    mod_74x161 #(.WIDTH(4)) dut    (.clk(clk), .clr_n(cur.clr_n), .bus(m_if.slave));
    mod_74x161 #(.WIDTH(4)) dut_lo (.clk(clk), .clr_n(cur.clr_n), .bus(lo_if.slave));
    mod_74x161 #(.WIDTH(4)) dut_hi (.clk(clk), .clr_n(cur.clr_n), .bus(hi_if.slave));

    initial begin
        clk = 1'b0;
        forever #(HALF_PERIOD) clk = ~clk;
    end

    // Expected outputs from the model: {q, rco, cascade value, lower rco, upper rco}
    function automatic logic [14:0] expect_now();
        logic [3:0] q4;
        logic [7:0] c8;
        logic       rco, lo_rco, hi_rco;
        q4     = 4'(mq);
        c8     = 8'(mc);
        rco    = cur.ent && (mq == 15);
        lo_rco = cur.c_ent && ((mc % 16) == 15);
        hi_rco = cur.c_ent && (mc == 255);
        return {q4, rco, c8, lo_rco, hi_rco};
    endfunction

    task automatic step(input stim_t nx, input string tag);
        exp_t e;
        @(posedge clk);
        if (!cur.clr_n)                mq = 0;
        else if (!cur.load_n)          mq = int'(cur.d);
        else if (cur.enp && cur.ent)   mq = (mq + 1) % 16;
        if (!cur.clr_n)                mc = 0;
        else if (!cur.c_load_n)        mc = int'(cur.c_d);
        else if (cur.c_enp && cur.c_ent) mc = (mc + 1) % 256;
        #1;
        cur = nx;
        if (!cur.clr_n) begin
            mq = 0;
            mc = 0;
        end
        e.v   = expect_now();
        e.tag = tag;
        sb.push_back(e);
    endtask

    function automatic stim_t mk(input logic clr, input logic ld, input logic p,
                                 input logic t, input logic [3:0] dd);
        stim_t s;
        s = '{clr_n: clr, load_n: ld, enp: p, ent: t, d: dd,
              c_load_n: 1'b1, c_enp: 1'b0, c_ent: 1'b0, c_d: 8'h00};
        return s;
    endfunction

    function automatic stim_t mkc(input logic ld, input logic p, input logic t,
                                  input logic [7:0] dd);
        stim_t s;
        s = '{clr_n: 1'b1, load_n: 1'b1, enp: 1'b0, ent: 1'b0, d: 4'h0,
              c_load_n: ld, c_enp: p, c_ent: t, c_d: dd};
        return s;
    endfunction

    // Monitor: every falling edge, retire all pending expectations against the outputs
    initial begin
        exp_t        e;
        logic [14:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {m_if.q, m_if.rco, hi_if.q, lo_if.q, lo_if.rco, hi_if.rco};
                vectors++;
                if (act !== e.v) begin
                    miscompares++;
                    $display("FAIL %s: got %h expected %h", e.tag, act, e.v);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: stimulus did not complete, queue depth %0d", sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        exp_t  e;
        stim_t s;
        vectors     = 0;
        miscompares = 0;
        stim_done   = 1'b0;
        mq          = 0;
        mc          = 0;
        cur         = mk(1'b0, 1'b1, 1'b1, 1'b1, 4'h0);
        e.v         = expect_now();
        e.tag       = "reset";
        sb.push_back(e);
        step(mk(1'b0, 1'b1, 1'b1, 1'b1, 4'h0), "reset_hold");

        // Async clear mid-count
        for (int i = 0; i < 6; i++) step(mk(1'b1, 1'b1, 1'b1, 1'b1, 4'h0), "count_up");
        step(mk(1'b0, 1'b1, 1'b1, 1'b1, 4'h0), "async_clear");
        for (int i = 0; i < 3; i++) step(mk(1'b0, 1'b1, 1'b1, 1'b1, 4'h0), "clear_hold");
        for (int i = 0; i < 3; i++) step(mk(1'b1, 1'b1, 1'b1, 1'b1, 4'h0), "clear_release");

        // Load priority with and without enables
        step(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'h3), "load_3");
        step(mk(1'b1, 1'b0, 1'b1, 1'b1, 4'hA), "load_over_count");
        step(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'hA), "load_enables_low");
        step(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'h0), "load_result");

        // Count through wrap
        step(mk(1'b1, 1'b0, 1'b1, 1'b1, 4'hE), "load_e");
        for (int i = 0; i < 3; i++) step(mk(1'b1, 1'b1, 1'b1, 1'b1, 4'h0), "wrap");

        // Enable gating from 7
        step(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'h7), "load_7");
        for (int i = 0; i < 2; i++) step(mk(1'b1, 1'b1, 1'b0, 1'b1, 4'h0), "enp_low");
        for (int i = 0; i < 2; i++) step(mk(1'b1, 1'b1, 1'b1, 1'b0, 4'h0), "ent_low");
        step(mk(1'b1, 1'b1, 1'b1, 1'b1, 4'h0), "both_high");
        step(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'h0), "count_8");

        // RCO follows ENT while Q is all-ones
        step(mk(1'b1, 1'b0, 1'b0, 1'b1, 4'hF), "load_f");
        step(mk(1'b1, 1'b1, 1'b0, 1'b1, 4'h0), "rco_ent1");
        step(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'h0), "rco_ent0");
        step(mk(1'b1, 1'b1, 1'b0, 1'b1, 4'h0), "rco_ent1_again");
        step(mk(1'b1, 1'b0, 1'b1, 1'b1, 4'hF), "rco_load_low");

        // Cascade: lower wrap carries into upper
        step(mkc(1'b0, 1'b0, 1'b0, 8'h0F), "casc_load_0f");
        step(mkc(1'b1, 1'b1, 1'b1, 8'h00), "casc_carry");
        step(mkc(1'b1, 1'b0, 1'b1, 8'h00), "casc_after");
        step(mkc(1'b0, 1'b0, 1'b1, 8'h00), "casc_load_0");
        for (int i = 0; i < 256; i++) step(mkc(1'b1, 1'b1, 1'b1, 8'h00), "casc_run");
        step(mkc(1'b1, 1'b0, 1'b1, 8'h00), "casc_done");

        // Randomised traffic on both counters
        for (int i = 0; i < 500; i++) begin
            s.clr_n    = ($urandom_range(15) != 0);
            s.load_n   = ($urandom_range(4) != 0);
            s.enp      = 1'($urandom);
            s.ent      = 1'($urandom);
            s.d        = 4'($urandom);
            s.c_load_n = ($urandom_range(19) != 0);
            s.c_enp    = ($urandom_range(3) != 0);
            s.c_ent    = ($urandom_range(3) != 0);
            s.c_d      = 8'($urandom);
            step(s, "random");
        end

        @(negedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        stim_done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
